// File: rtl/multicycle_sequencer.sv
// Multicycle FETCH/DECODE/EXEC/MEM/WB control sequencer.
// Generates per-phase enables and counts retired instructions.
module multicycle_sequencer #(
  parameter int EXEC_CYCLES = 1,
  parameter int CNT_W       = 16,
  parameter int MEM_TIMEOUT = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       op,
  input  logic             stall_i,
  input  logic             mem_ack,
  output logic             ir_en,
  output logic             pc_en,
  output logic             reg_wr_en,
  output logic             mem_rd_en,
  output logic             mem_wr_en,
  output logic             mem_timeout,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] retired,
  output logic             busy
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5
  } state_e;

  typedef enum logic [1:0] {
    C_ALU, C_LOAD, C_STORE, C_BRANCH
  } cls_e;

  localparam int TW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [3:0] EXEC_LAST = 4'(EXEC_CYCLES - 1);
  localparam logic [TW-1:0] TO_LAST =
    TW'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

  state_e           state_q, state_d;
  cls_e             cls_q, cls_d;
  logic [3:0]       ecnt_q, ecnt_d;
  logic [TW-1:0]    tcnt_q, tcnt_d;
  logic [CNT_W-1:0] ret_q, ret_d;
  logic             to_hit;

  function automatic cls_e op_class(input logic [5:0] o);
    cls_e c;
    c = C_ALU;
    unique case (1'b1)
      (o == 6'b100011): c = C_LOAD;
      (o == 6'b101011): c = C_STORE;
      (o == 6'b000100),
      (o == 6'b000101),
      (o == 6'b000111): c = C_BRANCH;
      default:          c = C_ALU;
    endcase
    return c;
  endfunction

  assign to_hit    = (MEM_TIMEOUT > 0) && (tcnt_q == TO_LAST);
  assign mem_rd_en = (state_q == S_MEM) && (cls_q == C_LOAD);
  assign mem_wr_en = (state_q == S_MEM) && (cls_q == C_STORE);
  assign state     = state_q;
  assign retired   = ret_q;
  assign busy      = (state_q != S_IDLE);

  always_comb begin
    state_d     = state_q;
    cls_d       = cls_q;
    ecnt_d      = ecnt_q;
    tcnt_d      = tcnt_q;
    ret_d       = ret_q;
    ir_en       = 1'b0;
    pc_en       = 1'b0;
    reg_wr_en   = 1'b0;
    mem_timeout = 1'b0;
    if (!stall_i) begin
      unique case (state_q)
        S_IDLE:   state_d = S_FETCH;
        S_FETCH: begin
          ir_en   = 1'b1;
          state_d = S_DECODE;
        end
        S_DECODE: begin
          cls_d   = op_class(op);
          ecnt_d  = EXEC_LAST;
          state_d = S_EXEC;
        end
        S_EXEC: begin
          if (ecnt_q == 4'd0) begin
            tcnt_d = '0;
            unique case (cls_q)
              C_BRANCH: begin
                pc_en   = 1'b1;
                state_d = S_FETCH;
              end
              C_LOAD, C_STORE: state_d = S_MEM;
              default:         state_d = S_WB;
            endcase
          end else begin
            ecnt_d = ecnt_q - 4'd1;
          end
        end
        S_MEM: begin
          mem_timeout = to_hit;
          if (mem_ack || to_hit) begin
            tcnt_d = '0;
            // A store retires on the very edge that completes it
            if (cls_q == C_LOAD) begin
              state_d = S_WB;
            end else begin
              pc_en   = 1'b1;
              state_d = S_FETCH;
            end
          end else begin
            tcnt_d = tcnt_q + TW'(1);
          end
        end
        S_WB: begin
          reg_wr_en = 1'b1;
          pc_en     = 1'b1;
          state_d   = S_FETCH;
        end
        default: state_d = S_IDLE;
      endcase
      if (pc_en) ret_d = ret_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cls_q   <= C_ALU;
      ecnt_q  <= '0;
      tcnt_q  <= '0;
      ret_q   <= '0;
    end else begin
      state_q <= state_d;
      cls_q   <= cls_d;
      ecnt_q  <= ecnt_d;
      tcnt_q  <= tcnt_d;
      ret_q   <= ret_d;
    end
  end

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Directed bench for multicycle_sequencer: two configurations
// (EXEC=1/CNT_W=4 and EXEC=3/MEM_TIMEOUT=4) sharing clock and reset.
module tb_multicycle_sequencer;

  logic clk, rst_n;

  logic [5:0]  a_op, b_op;
  logic        a_stall, b_stall, a_ack, b_ack;
  logic        a_ir, a_pc, a_rg, a_rd, a_wr, a_to, a_busy;
  logic        b_ir, b_pc, b_rg, b_rd, b_wr, b_to, b_busy;
  logic [2:0]  a_st, b_st;
  logic [3:0]  a_ret;
  logic [15:0] b_ret;
  logic [8:0]  a_obs, b_obs;

  int checks = 0;
  int errors = 0;
  int n = 0;

  multicycle_sequencer #(
    .EXEC_CYCLES(1), .CNT_W(4), .MEM_TIMEOUT(0)
  ) u_a (
    .clk(clk), .rst_n(rst_n), .op(a_op), .stall_i(a_stall),
    .mem_ack(a_ack), .ir_en(a_ir), .pc_en(a_pc), .reg_wr_en(a_rg),
    .mem_rd_en(a_rd), .mem_wr_en(a_wr), .mem_timeout(a_to),
    .state(a_st), .retired(a_ret), .busy(a_busy)
  );

  multicycle_sequencer #(
    .EXEC_CYCLES(3), .CNT_W(16), .MEM_TIMEOUT(4)
  ) u_b (
    .clk(clk), .rst_n(rst_n), .op(b_op), .stall_i(b_stall),
    .mem_ack(b_ack), .ir_en(b_ir), .pc_en(b_pc), .reg_wr_en(b_rg),
    .mem_rd_en(b_rd), .mem_wr_en(b_wr), .mem_timeout(b_to),
    .state(b_st), .retired(b_ret), .busy(b_busy)
  );

  assign a_obs = {a_st, a_ir, a_pc, a_rg, a_rd, a_wr, a_to};
  assign b_obs = {b_st, b_ir, b_pc, b_rg, b_rd, b_wr, b_to};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  function automatic logic [8:0] ev(input logic [2:0] s,
                                    input logic ir = 1'b0,
                                    input logic pc = 1'b0,
                                    input logic rg = 1'b0,
                                    input logic rd = 1'b0,
                                    input logic wr = 1'b0,
                                    input logic to = 1'b0);
    return {s, ir, pc, rg, rd, wr, to};
  endfunction

  task automatic cyc_a(input logic st, input logic ak,
                       input logic [8:0] e, input int r);
    a_stall = st;
    a_ack   = ak;
    #1;
    check($sformatf("a_out%0d", n), 32'(a_obs), 32'(e));
    check($sformatf("a_ret%0d", n), 32'(a_ret), r);
    n++;
    @(negedge clk);
  endtask

  task automatic cyc_b(input logic st, input logic ak,
                       input logic [8:0] e, input int r);
    b_stall = st;
    b_ack   = ak;
    #1;
    check($sformatf("b_out%0d", n), 32'(b_obs), 32'(e));
    check($sformatf("b_ret%0d", n), 32'(b_ret), r);
    n++;
    @(negedge clk);
  endtask

  logic [8:0] ta[6], tb[6];
  int ra[6], rb[6];

  initial begin
    ta = '{ev(1,1), ev(2), ev(3), ev(5,0,1,1), ev(1,1), ev(2)};
    tb = '{ev(1,1), ev(2), ev(3), ev(3), ev(3,0,1), ev(1,1)};
    ra = '{0, 0, 0, 0, 1, 1};
    rb = '{0, 0, 0, 0, 0, 1};

    rst_n   = 1'b0;
    a_op    = 6'b000000;
    b_op    = 6'b000100;
    a_stall = 1'b0;
    b_stall = 1'b0;
    a_ack   = 1'b0;
    b_ack   = 1'b0;

    @(negedge clk);
    check("rst_a_out", 32'(a_obs), 32'(0));
    check("rst_a_ret", 32'(a_ret), 0);
    check("rst_a_busy", 32'(a_busy), 0);
    check("rst_b_ret", 32'(b_ret), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // ALU on A and BRANCH on B straight out of reset
    for (int i = 0; i < 6; i++) begin
      #1;
      check($sformatf("p1_a%0d", i), 32'(a_obs), 32'(ta[i]));
      check($sformatf("p1_ar%0d", i), 32'(a_ret), ra[i]);
      check($sformatf("p1_b%0d", i), 32'(b_obs), 32'(tb[i]));
      check($sformatf("p1_br%0d", i), 32'(b_ret), rb[i]);
      if (i == 0) check("busy_a", 32'(a_busy), 1);
      @(negedge clk);
    end

    // park B in DECODE; A: finish ALU, then a LOAD with a lost ack
    b_stall = 1'b1;
    a_op    = 6'b100011;
    cyc_a(0, 0, ev(3), 1);
    cyc_a(0, 0, ev(5,0,1,1), 1);
    cyc_a(0, 0, ev(1,1), 2);
    cyc_a(0, 0, ev(2), 2);
    a_op = 6'b000000;
    cyc_a(0, 0, ev(3), 2);
    cyc_a(0, 0, ev(4,0,0,0,1), 2);
    cyc_a(1, 1, ev(4,0,0,0,1), 2);
    cyc_a(0, 0, ev(4,0,0,0,1), 2);
    cyc_a(0, 1, ev(4,0,0,0,1), 2);
    cyc_a(0, 0, ev(5,0,1,1), 2);
    cyc_a(0, 0, ev(1,1), 3);

    // ALU with a 5-cycle stall in WB
    cyc_a(0, 0, ev(2), 3);
    cyc_a(0, 0, ev(3), 3);
    repeat (5) cyc_a(1, 0, ev(5), 3);
    cyc_a(0, 0, ev(5,0,1,1), 3);
    cyc_a(0, 0, ev(1,1), 4);

    // 13 more ALU instructions: 4-bit counter wraps through 0
    for (int k = 0; k < 13; k++) begin
      cyc_a(0, 0, ev(2), (4 + k) % 16);
      cyc_a(0, 0, ev(3), (4 + k) % 16);
      cyc_a(0, 0, ev(5,0,1,1), (4 + k) % 16);
      cyc_a(0, 0, ev(1,1), (5 + k) % 16);
    end
    a_stall = 1'b1;
    #1;
    check("a_wrap", 32'(a_ret), 1);

    // B: STORE with no ack, stall mid-MEM, forced out by timeout
    b_op = 6'b101011;
    cyc_b(0, 0, ev(2), 1);
    repeat (3) cyc_b(0, 0, ev(3), 1);
    cyc_b(0, 0, ev(4,0,0,0,0,1), 1);
    cyc_b(0, 0, ev(4,0,0,0,0,1), 1);
    cyc_b(1, 0, ev(4,0,0,0,0,1), 1);
    cyc_b(0, 0, ev(4,0,0,0,0,1), 1);
    cyc_b(0, 0, ev(4,0,1,0,0,1,1), 1);
    cyc_b(0, 0, ev(1,1), 2);
    b_stall = 1'b1;

    // A: reset asserted in the middle of EXEC
    cyc_a(0, 0, ev(2), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_a_state", 32'(a_st), 0);
    check("mid_a_ret", 32'(a_ret), 0);
    check("mid_a_pc", 32'(a_pc), 0);
    check("mid_a_busy", 32'(a_busy), 0);
    check("mid_b_ret", 32'(b_ret), 0);
    check("mid_b_state", 32'(b_st), 0);
    @(negedge clk);
    #1;
    check("hold_a_out", 32'(a_obs), 32'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
